// File: rtl/mem_wb_stage_param.sv
// mem_wb_stage_param
//
// Memory/writeback pipeline stage with an internal word-addressed data RAM.
// Performs byte/half/word loads and stores (sign or zero extended loads),
// inserts MEM_LAT wait cycles per memory access through an IDLE/WAIT FSM,
// and registers the result into the MEM/WB register with flush and
// misalignment reporting.
//
// Parameters
//   DEPTH       number of 32-bit RAM words (power of two)
//   MEM_LAT     extra wait cycles per load/store, 0..7
//   REG_ADDR_W  destination register index width
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   valid_m .. flush    MEM-stage instruction fields and kill request
//   stall_m             upstream hold request (see handshake note below)
//   valid_w .. misalign_w  registered MEM/WB outputs
//
// Handshake: stall_m is a combinational hold. While stall_m=1 the upstream
// stage must keep every *_m input unchanged; the instruction is consumed on
// the first rising edge where stall_m=0. flush overrides everything except
// rst and always deasserts stall_m in the same cycle.

module mem_wb_stage_param #(
    parameter int DEPTH      = 1024,
    parameter int MEM_LAT    = 0,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic                  reg_wrt_m,
    input  logic                  mem_wrt_m,
    input  logic                  mem_rd_m,
    input  logic                  result_src_m,
    input  logic [1:0]            size_m,
    input  logic                  unsigned_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [31:0]           pc_plus4_m,
    input  logic [31:0]           write_data_m,
    input  logic [31:0]           alu_result_m,
    input  logic                  flush,
    output logic                  stall_m,
    output logic                  valid_w,
    output logic                  reg_write_w,
    output logic                  result_src_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [31:0]           pc_plus4_w,
    output logic [31:0]           alu_result_w,
    output logic [31:0]           read_data_w,
    output logic                  misalign_w
);

    localparam int       AW       = $clog2(DEPTH);
    localparam bit       HAS_LAT  = (MEM_LAT > 0);
    // Counter preset so that WAIT lasts exactly MEM_LAT cycles including
    // the completing one: IDLE(stall) + (MEM_LAT-1) counting + final edge.
    localparam logic [2:0] CNT_INIT = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       stall_c;

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    logic [AW-1:0] idx;
    logic [1:0]    boff;
    logic          is_mem;
    logic          access;
    logic          mis_addr;
    logic          misaligned;
    logic          unused_addr_bits;

    assign idx    = alu_result_m[AW+1:2];
    assign boff   = alu_result_m[1:0];
    // Upper address bits are deliberately dropped: addresses wrap mod DEPTH*4.
    assign unused_addr_bits = ^alu_result_m[31:AW+2];

    assign is_mem = valid_m & (mem_rd_m | mem_wrt_m);
    assign access = is_mem & ~flush;

    // size 11 behaves as word
    assign mis_addr   = ((size_m == 2'b01) & boff[0]) | (size_m[1] & (boff != 2'b00));
    assign misaligned = is_mem & mis_addr;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_c = 1'b0;
        if (flush) begin
            state_n = ST_IDLE;
            cnt_n   = 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && HAS_LAT) begin
                        state_n = ST_WAIT;
                        cnt_n   = CNT_INIT;
                        stall_c = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt_n   = cnt - 3'd1;
                        stall_c = 1'b1;
                    end else begin
                        // completing edge: access retires, back to IDLE
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign stall_m = stall_c;

    // A bubble enters W whenever the instruction is not retiring this edge.
    logic bubble;
    assign bubble = stall_c | flush;

    // ------------------------------------------------------------------
    // Data RAM (byte-lane writes, combinational read)
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    assign we = ~rst & ~bubble & valid_m & mem_wrt_m & ~misaligned;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = write_data_m;
        case (size_m)
            2'b00: begin
                be        = 4'b0001 << boff;
                wdata_rep = {4{write_data_m[7:0]}};
            end
            2'b01: begin
                be        = boff[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data_m[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = write_data_m;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    logic [31:0] rword;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign rword = mem[idx];

    always_comb begin
        byte_sel = rword[7:0];
        case (boff)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel  = boff[1] ? rword[31:16] : rword[15:0];
        load_data = 32'd0;
        if (mem_rd_m) begin
            case (size_m)
                2'b00:   load_data = unsigned_m ? {24'd0, byte_sel}
                                                : {{24{byte_sel[7]}}, byte_sel};
                2'b01:   load_data = unsigned_m ? {16'd0, half_sel}
                                                : {{16{half_sel[15]}}, half_sel};
                default: load_data = rword;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= '0;
            pc_plus4_w   <= 32'd0;
            alu_result_w <= 32'd0;
            read_data_w  <= 32'd0;
            misalign_w   <= 1'b0;
        end else if (bubble) begin
            // bubble: kill validity, keep the remaining fields
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= reg_wrt_m & valid_m & ~misaligned;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
            pc_plus4_w   <= pc_plus4_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= load_data;
            misalign_w   <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage_param.sv
// Testbench for mem_wb_stage_param: a zero-latency instance driven from a
// vector table, plus two MEM_LAT=3 instances (DEPTH 1024 and DEPTH 16)
// exercised with hand-written multi-cycle sequences.

module tb_mem_wb_stage_param;

    typedef struct packed {
        logic        v, rd, wr, rw;
        logic [1:0]  sz;
        logic        un;
        logic [4:0]  rdr;
        logic [31:0] pc, wd, ad;
        logic        fl;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        ev, erw, chk;
        logic [31:0] erd;
        logic        emis;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared DUT inputs ----------------
    logic        valid_m = 0, reg_wrt_m = 0, mem_wrt_m = 0, mem_rd_m = 0;
    logic        result_src_m = 0, unsigned_m = 0, flush = 0;
    logic [1:0]  size_m = 0;
    logic [4:0]  rd_m = 0;
    logic [31:0] pc_plus4_m = 0, write_data_m = 0, alu_result_m = 0;

    // ---------------- per-DUT outputs ----------------
    logic        s0, v0, rw0, rs0, m0;
    logic [4:0]  rd0;
    logic [31:0] pc0, al0, dt0;
    logic        s3, v3, rw3, rs3, m3;
    logic [4:0]  rd3;
    logic [31:0] pc3, al3, dt3;
    logic        s16, v16, rw16, rs16, m16;
    logic [4:0]  rd16;
    logic [31:0] pc16, al16, dt16;

    mem_wb_stage_param #(.DEPTH(1024), .MEM_LAT(0), .REG_ADDR_W(5)) u_lat0 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .reg_wrt_m(reg_wrt_m),
        .mem_wrt_m(mem_wrt_m), .mem_rd_m(mem_rd_m), .result_src_m(result_src_m),
        .size_m(size_m), .unsigned_m(unsigned_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m),
        .alu_result_m(alu_result_m), .flush(flush), .stall_m(s0),
        .valid_w(v0), .reg_write_w(rw0), .result_src_w(rs0), .rd_w(rd0),
        .pc_plus4_w(pc0), .alu_result_w(al0), .read_data_w(dt0), .misalign_w(m0)
    );

    mem_wb_stage_param #(.DEPTH(1024), .MEM_LAT(3), .REG_ADDR_W(5)) u_lat3 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .reg_wrt_m(reg_wrt_m),
        .mem_wrt_m(mem_wrt_m), .mem_rd_m(mem_rd_m), .result_src_m(result_src_m),
        .size_m(size_m), .unsigned_m(unsigned_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m),
        .alu_result_m(alu_result_m), .flush(flush), .stall_m(s3),
        .valid_w(v3), .reg_write_w(rw3), .result_src_w(rs3), .rd_w(rd3),
        .pc_plus4_w(pc3), .alu_result_w(al3), .read_data_w(dt3), .misalign_w(m3)
    );

    mem_wb_stage_param #(.DEPTH(16), .MEM_LAT(3), .REG_ADDR_W(5)) u_d16 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .reg_wrt_m(reg_wrt_m),
        .mem_wrt_m(mem_wrt_m), .mem_rd_m(mem_rd_m), .result_src_m(result_src_m),
        .size_m(size_m), .unsigned_m(unsigned_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m),
        .alu_result_m(alu_result_m), .flush(flush), .stall_m(s16),
        .valid_w(v16), .reg_write_w(rw16), .result_src_w(rs16), .rd_w(rd16),
        .pc_plus4_w(pc16), .alu_result_w(al16), .read_data_w(dt16), .misalign_w(m16)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    function automatic op_t mk(input logic v, rd, wr, rw, input logic [1:0] sz,
                               input logic un, input logic [31:0] wd, ad, input logic fl);
        op_t o;
        o.v = v; o.rd = rd; o.wr = wr; o.rw = rw; o.sz = sz; o.un = un;
        o.rdr = 5'd9; o.pc = 32'h100; o.wd = wd; o.ad = ad; o.fl = fl;
        return o;
    endfunction

    task automatic drive(input op_t o);
        valid_m      = o.v;
        mem_rd_m     = o.rd;
        mem_wrt_m    = o.wr;
        reg_wrt_m    = o.rw;
        result_src_m = o.rd;
        size_m       = o.sz;
        unsigned_m   = o.un;
        rd_m         = o.rdr;
        pc_plus4_m   = o.pc;
        write_data_m = o.wd;
        alu_result_m = o.ad;
        flush        = o.fl;
    endtask

    // One MEM_LAT=3 access on both latency instances; called just after a
    // falling edge. Expects stall for three cycles, then W valid after the
    // fourth rising edge.
    task automatic lat3_access(input op_t o, input logic [31:0] exp3,
                               input logic [31:0] exp16, input string nm);
        drive(o);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("%s stall3 c%0d", nm, c), 32'(s3), 32'd1);
            chk($sformatf("%s stall16 c%0d", nm, c), 32'(s16), 32'd1);
            if (c > 0) chk($sformatf("%s valid3 bubble c%0d", nm, c), 32'(v3), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk({nm, " stall3 done"}, 32'(s3), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " valid3"}, 32'(v3), 32'd1);
        chk({nm, " valid16"}, 32'(v16), 32'd1);
        chk({nm, " regw3"}, 32'(rw3), 32'(o.rw));
        chk({nm, " data3"}, dt3, exp3);
        chk({nm, " data16"}, dt16, exp16);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0));
    endtask

    vec_t vec [20];

    initial begin
        // ---- vector table for the MEM_LAT=0 instance ----
        //            v rd wr rw  sz    un wdata          addr          fl    ev erw chk erd           mis
        vec[0]  = '{mk(1,0,1,0,2'b10,0,32'hDEADBEEF,32'h10,0),       1'b1,1'b0,1'b1,32'h0,        1'b0};
        vec[1]  = '{mk(1,1,0,1,2'b10,0,32'h0,32'h10,0),              1'b1,1'b1,1'b1,32'hDEADBEEF, 1'b0};
        vec[2]  = '{mk(1,1,0,1,2'b00,0,32'h0,32'h11,0),              1'b1,1'b1,1'b1,32'hFFFFFFBE, 1'b0};
        vec[3]  = '{mk(1,1,0,1,2'b00,1,32'h0,32'h11,0),              1'b1,1'b1,1'b1,32'h000000BE, 1'b0};
        vec[4]  = '{mk(1,1,0,1,2'b01,0,32'h0,32'h12,0),              1'b1,1'b1,1'b1,32'hFFFFDEAD, 1'b0};
        vec[5]  = '{mk(1,0,1,0,2'b00,0,32'h55,32'h13,0),             1'b1,1'b0,1'b1,32'h0,        1'b0};
        vec[6]  = '{mk(1,1,0,1,2'b10,0,32'h0,32'h10,0),              1'b1,1'b1,1'b1,32'h55ADBEEF, 1'b0};
        // flushed store: bubble, read data holds, memory untouched
        vec[7]  = '{mk(1,0,1,0,2'b10,0,32'h99999999,32'h10,1),       1'b0,1'b0,1'b1,32'h55ADBEEF, 1'b0};
        vec[8]  = '{mk(1,1,0,1,2'b10,0,32'h0,32'h10,0),              1'b1,1'b1,1'b1,32'h55ADBEEF, 1'b0};
        vec[9]  = '{mk(1,0,1,0,2'b10,0,32'hCAFEF00D,32'h20,0),       1'b1,1'b0,1'b1,32'h0,        1'b0};
        vec[10] = '{mk(1,0,1,1,2'b10,0,32'h11111111,32'h22,0),       1'b1,1'b0,1'b1,32'h0,        1'b1};
        vec[11] = '{mk(1,1,0,1,2'b10,0,32'h0,32'h20,0),              1'b1,1'b1,1'b1,32'hCAFEF00D, 1'b0};
        vec[12] = '{mk(1,1,0,1,2'b01,0,32'h0,32'h21,0),              1'b1,1'b0,1'b0,32'h0,        1'b1};
        vec[13] = '{mk(1,1,0,1,2'b01,1,32'h0,32'h22,0),              1'b1,1'b1,1'b1,32'h0000CAFE, 1'b0};
        vec[14] = '{mk(1,0,1,0,2'b01,0,32'h1234ABCD,32'h22,0),       1'b1,1'b0,1'b1,32'h0,        1'b0};
        vec[15] = '{mk(1,1,0,1,2'b10,0,32'h0,32'h20,0),              1'b1,1'b1,1'b1,32'hABCDF00D, 1'b0};
        vec[16] = '{mk(1,0,0,1,2'b10,0,32'h0,32'h1235,0),            1'b1,1'b1,1'b1,32'h0,        1'b0};
        vec[17] = '{mk(0,0,0,1,2'b10,0,32'h0,32'h10,0),              1'b0,1'b0,1'b1,32'h0,        1'b0};
        // 0x1010 wraps onto word 4 (0x10) in a 1024-word RAM
        vec[18] = '{mk(1,0,1,0,2'b00,0,32'h7F,32'h1010,0),           1'b1,1'b0,1'b1,32'h0,        1'b0};
        vec[19] = '{mk(1,1,0,1,2'b11,0,32'h0,32'h10,0),              1'b1,1'b1,1'b1,32'h55ADBE7F, 1'b0};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_w", 32'(v0), 0);
        chk("rst reg_write_w", 32'(rw0), 0);
        chk("rst result_src_w", 32'(rs0), 0);
        chk("rst rd_w", 32'(rd0), 0);
        chk("rst pc_plus4_w", pc0, 0);
        chk("rst alu_result_w", al0, 0);
        chk("rst read_data_w", dt0, 0);
        chk("rst misalign_w", 32'(m0), 0);
        chk("rst stall_m", 32'(s0), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- MEM_LAT=0 table ----
        for (int i = 0; i < 20; i++) begin
            op_t o;
            o     = vec[i].op;
            o.rdr = 5'(i + 1);
            o.pc  = 32'h1000 + 32'(4 * i);
            @(negedge clk);
            drive(o);
            #1;
            chk($sformatf("v%0d stall_m", i), 32'(s0), 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_w", i), 32'(v0), 32'(vec[i].ev));
            chk($sformatf("v%0d reg_write_w", i), 32'(rw0), 32'(vec[i].erw));
            if (vec[i].chk) chk($sformatf("v%0d read_data_w", i), dt0, vec[i].erd);
            chk($sformatf("v%0d misalign_w", i), 32'(m0), 32'(vec[i].emis));
            if (!o.fl) begin
                chk($sformatf("v%0d rd_w", i), 32'(rd0), 32'(o.rdr));
                chk($sformatf("v%0d alu_result_w", i), al0, o.ad);
                chk($sformatf("v%0d pc_plus4_w", i), pc0, o.pc);
                chk($sformatf("v%0d result_src_w", i), 32'(rs0), 32'(o.rd));
            end
        end

        // ---- MEM_LAT=3 sequences; restart the FSMs first ----
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // latency and load data
        lat3_access(mk(1,0,1,0,2'b10,0,32'hA5A5A5A5,32'h40,0), 32'h0, 32'h0, "sw40");
        lat3_access(mk(1,1,0,1,2'b10,0,32'h0,32'h40,0), 32'hA5A5A5A5, 32'hA5A5A5A5, "lw40");

        // ALU op right after a load: no stall, one cycle
        begin
            op_t a;
            a = mk(1, 0, 0, 1, 2'b10, 0, 32'h0, 32'hABCD, 0);
            a.rdr = 5'd7;
            a.pc  = 32'h2004;
            drive(a);
            #1;
            chk("alu stall3", 32'(s3), 0);
            @(posedge clk);
            #1;
            chk("alu valid3", 32'(v3), 1);
            chk("alu regw3", 32'(rw3), 1);
            chk("alu result3", al3, 32'hABCD);
        end

        // flush in the first WAIT cycle of a store
        @(negedge clk);
        drive(mk(1,0,1,0,2'b10,0,32'h12345678,32'h40,0));
        #1;
        chk("fl stall c0", 32'(s3), 1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl stall c1", 32'(s3), 0);
        @(posedge clk);
        #1;
        chk("fl valid3", 32'(v3), 0);
        chk("fl regw3", 32'(rw3), 0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0));
        #1;
        chk("fl stall after", 32'(s3), 0);
        lat3_access(mk(1,1,0,1,2'b10,0,32'h0,32'h40,0), 32'hA5A5A5A5, 32'hA5A5A5A5, "fl lw40");

        // address wrap: 0x44 aliases word 1 only in the 16-word RAM
        lat3_access(mk(1,0,1,0,2'b10,0,32'h0BADF00D,32'h04,0), 32'h0, 32'h0, "sw04");
        lat3_access(mk(1,0,1,0,2'b10,0,32'hFEEDFACE,32'h44,0), 32'h0, 32'h0, "sw44");
        lat3_access(mk(1,1,0,1,2'b10,0,32'h0,32'h04,0), 32'h0BADF00D, 32'hFEEDFACE, "lw04");

        // reset in the middle of WAIT: put non-zero content in W first
        begin
            op_t a;
            a = mk(1, 0, 0, 1, 2'b10, 0, 32'h0, 32'h5678, 0);
            a.rdr = 5'd11;
            a.pc  = 32'h3008;
            drive(a);
            @(posedge clk);
            #1;
            chk("pre-rst valid16", 32'(v16), 1);
        end
        @(negedge clk);
        drive(mk(1,1,0,1,2'b10,0,32'h0,32'h04,0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst16 valid_w", 32'(v16), 0);
        chk("rst16 reg_write_w", 32'(rw16), 0);
        chk("rst16 result_src_w", 32'(rs16), 0);
        chk("rst16 rd_w", 32'(rd16), 0);
        chk("rst16 pc_plus4_w", pc16, 0);
        chk("rst16 alu_result_w", al16, 0);
        chk("rst16 read_data_w", dt16, 0);
        chk("rst16 misalign_w", 32'(m16), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0));
        #1;
        chk("rst16 stall_m", 32'(s16), 0);
        chk("rst3 stall_m", 32'(s3), 0);
        @(posedge clk);
        @(negedge clk);
        // RAM contents survive reset
        lat3_access(mk(1,1,0,1,2'b10,0,32'h0,32'h04,0), 32'h0BADF00D, 32'hFEEDFACE, "post-rst lw04");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_param.md
Name: mem_wb_stage_param

Overview:
- Parametrised successor to the single-cycle memory/writeback pipeline stage.
- Holds an internal word-addressed data RAM and performs byte, halfword and word loads and stores, with sign or zero extension on loads.
- Supports a configurable memory latency, stalling upstream with a wait-state FSM while an access is in progress.
- Registers the result into the MEM/WB pipeline register, with flush and misalignment detection.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; must be a power of two.
- MEM_LAT, 0, extra wait cycles per load or store; legal range 0..7.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_m  input  1  an instruction is present in MEM.
- reg_wrt_m  input  1  instruction writes the register file.
- mem_wrt_m  input  1  store.
- mem_rd_m  input  1  load.
- result_src_m  input  1  writeback mux select: 0 = ALU, 1 = load data.
- size_m  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- unsigned_m  input  1  zero-extend loads when 1.
- rd_m  input  REG_ADDR_W  destination register.
- pc_plus4_m  input  32  PC+4.
- write_data_m  input  32  store data, right-aligned.
- alu_result_m  input  32  byte address or ALU result.
- flush  input  1  kill the current MEM instruction.
- stall_m  output  1  upstream must hold all *_m inputs stable.
- valid_w  output  1  W register holds a valid instruction.
- reg_write_w  output  1  register-file write enable.
- result_src_w  output  1  registered result_src_m.
- rd_w  output  REG_ADDR_W  registered rd_m.
- pc_plus4_w  output  32  registered pc_plus4_m.
- alu_result_w  output  32  registered alu_result_m.
- read_data_w  output  32  extended load data.
- misalign_w  output  1  registered misalignment flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All W outputs go to 0; stall_m is 0.
  - FSM goes to IDLE; wait counter is 0.
  - RAM contents are not cleared.
- Word index = alu_result_m[2+log2(DEPTH)-1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Access = valid_m & (mem_rd_m | mem_wrt_m) & ~flush.
- Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned access commits no write.
  - It produces misalign_w=1, reg_write_w=0, valid_w=1.
  - It takes the same latency as an aligned access.
- FSM states IDLE and WAIT:
  - IDLE, access, MEM_LAT>0: go to WAIT, cnt=MEM_LAT-1, stall_m=1 combinationally this cycle. The W register loads a bubble: valid_w=0, reg_write_w=0, other W fields hold.
  - WAIT, cnt>0: cnt decrements, stall_m=1, W loads a bubble.
  - WAIT, cnt=0: stall_m=0. The access completes on this edge (RAM write and W register load), then the FSM goes to IDLE.
  - IDLE with no access, or MEM_LAT=0: stall_m=0, and the W register loads every cycle (single-cycle behaviour).
  - Total latency from the first presentation of the instruction to W valid is MEM_LAT+1 edges.
- Store lane enables by size:
  - Byte: lane addr[1:0] gets write_data_m[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get write_data_m[15:0].
  - Word: all four lanes.
  - Unselected bytes are unchanged.
- Load:
  - Read is combinational from the array and sampled on the completing edge.
  - The selected byte or half is shifted to bit 0, then sign-extended (unsigned_m=0) or zero-extended (unsigned_m=1).
  - read_data_w = 0 for non-loads.
- W load, non-bubble: valid_w=valid_m; reg_write_w=reg_wrt_m & valid_m & ~misaligned; remaining fields copied from the *_m inputs.
- flush:
  - In any state, flush has priority: the FSM goes to IDLE, cnt=0, stall_m=0, and W loads a bubble.
  - No RAM write occurs on that edge, including an aborted store in WAIT.
- rst has priority over flush.
- Non-memory instructions never stall and pass through in 1 cycle.
- A load or store issued the cycle after a store to the same word sees the new data.

Test Plan:
- MEM_LAT=0: store word 0xDEADBEEF at 0x10, then load word from 0x10 → next cycle read_data_w=0xDEADBEEF, reg_write_w=1, stall_m never asserted.
- Byte/half extension: after the word store above, lb 0x11 → 0xFFFFFFBE; lbu 0x11 → 0x000000BE; lh 0x12 → 0xFFFFDEAD; sb 0x55 to 0x13, then lw 0x10 → 0x55ADBEEF.
- MEM_LAT=3: lw issued at cycle 0 → stall_m=1 in cycles 0–2, valid_w=0 in those cycles, valid_w=1 with data after edge 3; an ALU op following it sees no stall.
- Misalignment: sw to 0x22 → misalign_w=1, reg_write_w=0, and word 0x20 is unchanged on readback; lh 0x21 → misalign_w=1.
- Flush mid-WAIT (MEM_LAT=3): sw 0x12345678 to 0x40 with flush asserted in cycle 1 → stall_m drops next cycle, valid_w=0, and a subsequent lw 0x40 returns the old value.
- Reset/wrap (DEPTH=16): store to 0x44 aliases word 1; rst mid-WAIT → all W outputs 0, stall_m=0 next cycle, RAM contents retained.
